bitlet_pack_fixed_mc: RTL and testbench

//  Multi-lane, parametrised fixed-point packer at the accumulator back end of the Bitlet PE array.
//  Per lane: takes a two's-complement accumulator word, arithmetic-right-shifts it by a runtime quant

---
 rtl/bitlet_pack_fixed_mc.sv | 152 +++++++++++++++
 tb/tb_bitlet_pack_fixed_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitlet_pack_fixed_mc.sv
// bitlet_pack_fixed_mc
// Multi-lane fixed-point packer for the back end of the Bitlet PE array accumulators.
// Each lane takes a two's-complement accumulator word and arithmetic-right-shifts it by a
// per-beat quant amount. Rounding is optional. The result is saturated to OUT_W bits and an
// overflow flag is raised when saturation happens. All lanes share one handshake and one
// quant/mode. A sticky counter records the beats that saturated.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_vld       input beat valid
//   in_rdy       block can accept a beat this cycle (does not depend on in_vld)
//   in_acc       LANES x ACC_W accumulators, lane i at [i*ACC_W +: ACC_W]
//   in_quant     right-shift amount, sampled with the beat
//   in_mode      00 truncate (floor), 01 round-half-up, 1x truncate
//   out_vld      output beat valid
//   out_rdy      downstream accepts the beat
//   out_res      LANES x OUT_W packed results, lane i at [i*OUT_W +: OUT_W]
//   out_sat      per-lane saturation flags, aligned with out_res
//   sat_cnt      number of consumed beats with any out_sat bit set (sticks at all-ones)
//   sat_clr      synchronous clear of sat_cnt; wins over a same-cycle increment
//
// Handshake: a beat moves across an interface on a rising edge where valid and ready are
// both high. A producer holds valid and data stable until that edge. in_rdy is a function
// of pipeline occupancy and out_rdy only. out_vld/out_res/out_sat stay put until consumed.
//
// Pipeline: S1 holds the rounded+shifted value (ACC_W+1 bits per lane). S2 holds the
// saturated result and drives the outputs directly. A beat accepted on one edge is
// registered in S1 on that edge. It reaches the outputs on the following edge.
module bitlet_pack_fixed_mc #(
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int QUANT_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [LANES*ACC_W-1:0]   in_acc,
  input  logic [QUANT_W-1:0]       in_quant,
  input  logic [1:0]               in_mode,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [LANES*OUT_W-1:0]   out_res,
  output logic [LANES-1:0]         out_sat,
  output logic [CNT_W-1:0]         sat_cnt,
  input  logic                     sat_clr
);

  // One guard bit above the accumulator means the rounding bias can never wrap.
  localparam int TW = ACC_W + 1;

  // Largest legal shift: limited by the field width and by the headroom above OUT_W.
  localparam int Q_LIM = ((ACC_W - OUT_W) < (2**QUANT_W - 1)) ? (ACC_W - OUT_W)
                                                              : (2**QUANT_W - 1);

  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = {{(TW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]     RES_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     RES_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                   s1_vld;
  logic [LANES*TW-1:0]    s1_t;
  logic [LANES*TW-1:0]    t_next;
  logic [LANES*OUT_W-1:0] res_next;
  logic [LANES-1:0]       sat_next;

  logic                   s1_load;
  logic                   s2_load;
  logic                   in_fire;
  logic                   out_fire;
  logic [QUANT_W-1:0]     q_eff;
  logic                   round_en;

  // Stage control: a stage loads when it is empty or its content leaves this cycle.
  assign out_fire = out_vld & out_rdy;
  assign s2_load  = !out_vld | out_rdy;
  assign s1_load  = !s1_vld | s2_load;
  assign in_rdy   = s1_load;
  assign in_fire  = in_vld & in_rdy;

  // Shift amounts beyond the legal range clamp to the limit.
  assign q_eff    = (int'(in_quant) > Q_LIM) ? QUANT_W'(Q_LIM) : in_quant;
  // A zero shift has no fractional bits, so rounding adds nothing.
  assign round_en = (in_mode == 2'b01) && (q_eff != '0);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [TW-1:0] acc_ext;
    logic signed [TW-1:0] bias;
    logic signed [TW-1:0] sum;
    logic signed [TW-1:0] t_val;
    logic signed [TW-1:0] t_s;
    logic                 sat_hi;
    logic                 sat_lo;

    // S1 input side: sign-extend, add the half-LSB bias when rounding, then shift.
    assign acc_ext = TW'($signed(in_acc[i*ACC_W +: ACC_W]));
    assign bias    = round_en ? (TW'(1) << (q_eff - QUANT_W'(1))) : '0;
    assign sum     = acc_ext + bias;
    assign t_val   = sum >>> q_eff;
    assign t_next[i*TW +: TW] = t_val;

    // S2 input side: clamp the wide value into OUT_W bits.
    assign t_s     = s1_t[i*TW +: TW];
    assign sat_hi  = (t_s > SAT_MAX);
    assign sat_lo  = (t_s < SAT_MIN);
    assign res_next[i*OUT_W +: OUT_W] = sat_hi ? RES_MAX :
                                        sat_lo ? RES_MIN : t_s[OUT_W-1:0];
    assign sat_next[i] = sat_hi | sat_lo;
  end

  // Stage 1: shifted/rounded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_t   <= '0;
    end else if (s1_load) begin
      s1_vld <= in_fire;
      if (in_fire) begin
        s1_t <= t_next;
      end
    end
  end

  // Stage 2: saturated result, which is the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_res <= '0;
      out_sat <= '0;
    end else if (s2_load) begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_res <= res_next;
        out_sat <= sat_next;
      end
    end
  end

  // Saturation event counter: one count per consumed beat with any lane saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_fire && (|out_sat) && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bitlet_pack_fixed_mc.sv
// Directed bench for bitlet_pack_fixed_mc (LANES=4, ACC_W=32, OUT_W=16, QUANT_W=4).
// The counter is built 4 bits wide so that its all-ones ceiling can be reached quickly.
module tb_bitlet_pack_fixed_mc;

  localparam int LANES   = 4;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int QUANT_W = 4;
  localparam int CNT_W   = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   in_vld;
  logic                   in_rdy;
  logic [LANES*ACC_W-1:0] in_acc;
  logic [QUANT_W-1:0]     in_quant;
  logic [1:0]             in_mode;
  logic                   out_vld;
  logic                   out_rdy;
  logic [LANES*OUT_W-1:0] out_res;
  logic [LANES-1:0]       out_sat;
  logic [CNT_W-1:0]       sat_cnt;
  logic                   sat_clr;

  int errors = 0;
  int checks = 0;

  bitlet_pack_fixed_mc #(
    .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .QUANT_W(QUANT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_acc(in_acc),
    .in_quant(in_quant), .in_mode(in_mode),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res), .out_sat(out_sat),
    .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lanes4(input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Small in-range pattern: lane i of beat k carries k*4+i, which passes through unchanged.
  function automatic logic [127:0] bp_acc(input int k);
    return {32'(k*4+3), 32'(k*4+2), 32'(k*4+1), 32'(k*4)};
  endfunction

  function automatic logic [63:0] bp_res(input int k);
    return {16'(k*4+3), 16'(k*4+2), 16'(k*4+1), 16'(k*4)};
  endfunction

  // Single beat with out_rdy=1 and an empty pipeline, entered at posedge+1.
  // Returns at posedge+1 with the beat on the outputs; the next edge consumes it.
  task automatic run_one(input string tag, input logic [127:0] acc, input logic [3:0] q,
                         input logic [1:0] mode, input logic [63:0] exp_res,
                         input logic [3:0] exp_sat);
    in_acc   = acc;
    in_quant = q;
    in_mode  = mode;
    in_vld   = 1'b1;
    #1;
    chk({tag, ".in_rdy"}, 64'(in_rdy), 64'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    chk({tag, ".early_vld"}, 64'(out_vld), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ".out_vld"}, 64'(out_vld), 64'd1);
    chk({tag, ".res"}, out_res, exp_res);
    chk({tag, ".sat"}, 64'(out_sat), 64'(exp_sat));
  endtask

  // Saturating beat: lane0 far above +32767 with no shift.
  localparam logic [127:0] SAT_ACC = {32'h0, 32'h0, 32'h0, 32'h0010_0000};
  localparam logic [63:0]  SAT_RES = 64'h0000_0000_0000_7FFF;

  logic [63:0] exp_q[$];

  // ---------------- directed sequence ----------------
  initial begin
    int sent;
    int rcvd;
    int rdy_low;

    rst_n    = 1'b0;
    in_vld   = 1'b0;
    in_acc   = '0;
    in_quant = '0;
    in_mode  = '0;
    out_rdy  = 1'b1;
    sat_clr  = 1'b0;

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_vld", 64'(out_vld), 64'd0);
    chk("rst.out_res", out_res, 64'd0);
    chk("rst.out_sat", 64'(out_sat), 64'd0);
    chk("rst.sat_cnt", 64'(sat_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_rdy", 64'(in_rdy), 64'd1);

    // Truncate and round on positive/negative values, q=4.
    run_one("beat_a", lanes4(32'h0001_2345, 32'h18, 32'hFFFF_FFE8, 32'h8000_0000), 4'd4, 2'b00,
            64'h8000_FFFE_0001_1234, 4'b1000);
    run_one("beat_b", lanes4(32'h0001_2345, 32'h18, 32'hFFFF_FFE8, 32'h0007_FFF8), 4'd4, 2'b01,
            64'h7FFF_FFFF_0002_1234, 4'b1000);
    // q=0: exact boundaries of the 16-bit range and one step past each.
    run_one("beat_c", lanes4(32'h0010_0000, 32'h0000_7FFF, 32'hFFFF_8000, 32'hFFFF_7FFF), 4'd0, 2'b00,
            64'h8000_8000_7FFF_7FFF, 4'b1001);
    // q=15 rounding: 0x7FFFFFFF plus bias must not wrap negative.
    run_one("beat_d", lanes4(32'h7FFF_FFFF, 32'h0, 32'h0001_4000, 32'hFFFF_4000), 4'd15, 2'b01,
            64'hFFFF_0003_0000_7FFF, 4'b0001);
    // Reserved mode 10 behaves as truncate.
    run_one("beat_e", lanes4(32'h0001_4000, 32'hFFFF_4000, 32'h0, 32'h0), 4'd15, 2'b10,
            64'h0000_0000_FFFE_0002, 4'b0000);
    run_one("beat_f", lanes4(32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD, 32'h0000_FFFE), 4'd1, 2'b00,
            64'h7FFF_FFFE_0001_FFFF, 4'b0000);
    run_one("beat_g", lanes4(32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD, 32'h0000_FFFE), 4'd1, 2'b01,
            64'h7FFF_FFFF_0002_0000, 4'b0000);
    run_one("beat_h", lanes4(32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD, 32'h0000_FFFE), 4'd1, 2'b11,
            64'h7FFF_FFFE_0001_FFFF, 4'b0000);
    @(posedge clk);
    #1;
    chk("cnt.after_a_to_h", 64'(sat_cnt), 64'd4);
    chk("drain.out_vld", 64'(out_vld), 64'd0);

    // Backpressure: 8 beats back to back, out_rdy low in cycles 3..5.
    sent    = 0;
    rcvd    = 0;
    rdy_low = 0;
    in_quant = 4'd0;
    in_mode  = 2'b00;
    for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
      out_rdy = !(cyc >= 3 && cyc <= 5);
      in_vld  = (sent < 8);
      if (sent < 8) in_acc = bp_acc(sent);
      #1;
      if (!in_rdy) rdy_low++;
      if (!out_rdy) chk("bp.in_rdy_stall", 64'(in_rdy), 64'd0);
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          chk("bp.unexpected_beat", 64'(out_vld), 64'd0);
        end else begin
          chk("bp.res", out_res, exp_q[0]);
          chk("bp.sat", 64'(out_sat), 64'd0);
          if (out_rdy) begin
            void'(exp_q.pop_front());
            rcvd++;
          end
        end
      end
      if (in_vld && in_rdy) begin
        exp_q.push_back(bp_res(sent));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    chk("bp.received", 64'(rcvd), 64'd8);
    chk("bp.sent", 64'(sent), 64'd8);
    chk("bp.queue_empty", 64'(exp_q.size()), 64'd0);
    chk("bp.rdy_low_cycles", 64'(rdy_low), 64'd3);
    chk("bp.idle_after", 64'(out_vld), 64'd0);

    // Counter: clear alone, count 5, then clear together with a 6th increment.
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("cnt.clear", 64'(sat_cnt), 64'd0);
    for (int k = 0; k < 5; k++) run_one("cnt_beat", SAT_ACC, 4'd0, 2'b00, SAT_RES, 4'b0001);
    @(posedge clk);
    #1;
    chk("cnt.five", 64'(sat_cnt), 64'd5);
    run_one("cnt_beat6", SAT_ACC, 4'd0, 2'b00, SAT_RES, 4'b0001);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("cnt.clr_wins", 64'(sat_cnt), 64'd0);

    // Counter ceiling: 16 saturating beats into a 4-bit counter stop at 15.
    for (int k = 0; k < 16; k++) run_one("cnt_ceil", SAT_ACC, 4'd0, 2'b00, SAT_RES, 4'b0001);
    @(posedge clk);
    #1;
    chk("cnt.ceiling", 64'(sat_cnt), 64'd15);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;

    // Reset with both stages full.
    run_one("pre_rst", SAT_ACC, 4'd0, 2'b00, SAT_RES, 4'b0001);
    @(posedge clk);
    #1;
    chk("pre_rst.cnt", 64'(sat_cnt), 64'd1);
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_acc  = bp_acc(20);
    @(posedge clk);
    #1;
    in_acc  = bp_acc(21);
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    chk("full.out_vld", 64'(out_vld), 64'd1);
    chk("full.in_rdy", 64'(in_rdy), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_vld", 64'(out_vld), 64'd0);
    chk("midrst.sat_cnt", 64'(sat_cnt), 64'd0);
    chk("midrst.out_res", out_res, 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst.idle", 64'(out_vld), 64'd0);
    run_one("postrst", lanes4(32'h0001_2345, 32'h0, 32'h0, 32'h0), 4'd4, 2'b00,
            64'h0000_0000_0000_1234, 4'b0000);
    @(posedge clk);
    #1;
    chk("postrst.drained", 64'(out_vld), 64'd0);
    chk("postrst.cnt", 64'(sat_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
